// File: rtl/lab4_dec.sv
// Decryption stage for the lab4 encryptor: strips and checks the preamble,
// then undoes the 5-bit LFSR whitening on each message byte.
module lab4_dec #(
  parameter int LW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfgLoad,
  input  logic [7:0]    cfgPreLen,
  input  logic [LW-1:0] cfgTaps,
  input  logic [LW-1:0] cfgSeed,
  input  logic [7:0]    cfgMsgLen,
  input  logic          start,
  input  logic          validIn,
  input  logic [DW-1:0] encByte,
  output logic [DW-1:0] plainByte,
  output logic          validOut,
  output logic          busy,
  output logic          done,
  output logic          preErr,
  output logic          dataErr,
  output logic [7:0]    dataCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [DW-1:0] PRE_BYTE = DW'(8'h7E);

  state_e        state_q, state_d;
  logic [7:0]    preLen_q, preLen_d;
  logic [7:0]    msgLen_q, msgLen_d;
  logic [LW-1:0] taps_q, taps_d;
  logic [LW-1:0] seed_q, seed_d;
  logic [LW-1:0] lfsr_q, lfsr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [DW-1:0] plain_q, plain_d;
  logic          valid_q, valid_d;
  logic          preErr_q, preErr_d;
  logic          dataErr_q, dataErr_d;
  logic [7:0]    dataCount_q, dataCount_d;

  logic [LW-1:0] lfsrNext;
  logic [DW-1:0] lfsrExt;
  logic          launch;

  assign lfsrNext = {lfsr_q[LW-2:0], ^(lfsr_q & taps_q)};
  assign lfsrExt  = {{(DW-LW){1'b0}}, lfsr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      preLen_q    <= '0;
      msgLen_q    <= '0;
      taps_q      <= '0;
      seed_q      <= '0;
      lfsr_q      <= '0;
      cnt_q       <= '0;
      plain_q     <= '0;
      valid_q     <= 1'b0;
      preErr_q    <= 1'b0;
      dataErr_q   <= 1'b0;
      dataCount_q <= '0;
    end else begin
      state_q     <= state_d;
      preLen_q    <= preLen_d;
      msgLen_q    <= msgLen_d;
      taps_q      <= taps_d;
      seed_q      <= seed_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      plain_q     <= plain_d;
      valid_q     <= valid_d;
      preErr_q    <= preErr_d;
      dataErr_q   <= dataErr_d;
      dataCount_q <= dataCount_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    preLen_d    = preLen_q;
    msgLen_d    = msgLen_q;
    taps_d      = taps_q;
    seed_d      = seed_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    plain_d     = plain_q;
    valid_d     = 1'b0;
    preErr_d    = preErr_q;
    dataErr_d   = dataErr_q;
    dataCount_d = dataCount_q;
    launch      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfgLoad) begin
          preLen_d = cfgPreLen;
          msgLen_d = cfgMsgLen;
          taps_d   = cfgTaps;
          seed_d   = cfgSeed;
        end
        launch = start;
      end

      PRE: begin
        if (validIn) begin
          if (encByte != (PRE_BYTE ^ lfsrExt)) preErr_d = 1'b1;
          lfsr_d = lfsrNext;
          // Last preamble byte: the next accepted byte belongs to the message.
          if (cnt_q == preLen_q - 8'd1) begin
            cnt_d   = '0;
            state_d = (msgLen_q != 8'd0) ? DATA : DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      DATA: begin
        if (validIn) begin
          plain_d     = {1'b0, encByte[DW-2:0]} ^ lfsrExt;
          valid_d     = 1'b1;
          dataCount_d = dataCount_q + 8'd1;
          if (!encByte[DW-1]) dataErr_d = 1'b1;
          lfsr_d = lfsrNext;
          if (cnt_q == msgLen_q - 8'd1) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      DONE: begin
        launch = start;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A new run always replays the LFSR from the stored seed.
    if (launch) begin
      lfsr_d      = seed_q;
      cnt_d       = '0;
      preErr_d    = 1'b0;
      dataErr_d   = 1'b0;
      dataCount_d = '0;
      if (preLen_q != 8'd0)      state_d = PRE;
      else if (msgLen_q != 8'd0) state_d = DATA;
      else                       state_d = DONE;
    end
  end

  assign plainByte = plain_q;
  assign validOut  = valid_q;
  assign busy      = (state_q == PRE) || (state_q == DATA);
  assign done      = (state_q == DONE);
  assign preErr    = preErr_q;
  assign dataErr   = dataErr_q;
  assign dataCount = dataCount_q;

endmodule
